// File: rtl/s820_bist_ctrl.sv
// BIST sequencer for the s820 benchmark: an 18-bit LFSR drives the circuit
// inputs and a 19-bit MISR compacts its outputs into a signature.
module s820_bist_ctrl #(
    parameter int NPAT = 256
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [17:0] seed,
    input  logic [18:0] golden,
    output logic [17:0] dut_in,
    input  logic [18:0] dut_out,
    output logic        busy,
    output logic        done,
    output logic [18:0] signature,
    output logic        pass
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam logic [15:0] LAST_PAT = 16'(NPAT - 1);
    localparam logic [18:0] MISR_POLY = 19'h00027;

    state_t      state;
    state_t      next_state;
    logic [17:0] lfsr;
    logic [17:0] lfsr_n;
    logic [18:0] misr;
    logic [18:0] misr_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [18:0] misr_step;
    logic [17:0] lfsr_step;

    assign lfsr_step = {lfsr[16:0], lfsr[17] ^ lfsr[10]};
    assign misr_step = ({misr[17:0], 1'b0} ^ (misr[18] ? MISR_POLY : 19'h00000)) ^ dut_out;

    // Abort wins over everything while busy and discards the rest of the run.
    always_comb begin
        next_state = state;
        lfsr_n     = lfsr;
        misr_n     = misr;
        cnt_n      = cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = INIT;
                    lfsr_n     = (seed == 18'h00000) ? 18'h00001 : seed;
                    misr_n     = '0;
                    cnt_n      = '0;
                end
            end
            INIT: begin
                next_state = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    misr_n = misr_step;
                    lfsr_n = lfsr_step;
                    if (cnt == LAST_PAT) begin
                        next_state = FLUSH;
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
            end
            FLUSH: begin
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    misr_n     = misr_step;
                    next_state = DONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lfsr  <= 18'h00001;
            misr  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            lfsr  <= lfsr_n;
            misr  <= misr_n;
            cnt   <= cnt_n;
            busy  <= (next_state == INIT) || (next_state == RUN) || (next_state == FLUSH);
            done  <= (next_state == DONE);
        end
    end

    // G18 (bit 17) is the circuit's synchronous clear, pulsed only in INIT.
    always_comb begin
        dut_in = 18'h00000;
        case (state)
            INIT:    dut_in = 18'h20000;
            RUN:     dut_in = {1'b0, lfsr[16:0]};
            default: dut_in = 18'h00000;
        endcase
    end

    assign signature = misr;
    assign pass      = done && (misr == golden);

endmodule
